// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single-port RAM between instruction fetch (IF) and data load/store
// (DM) using request/grant/valid handshakes. DM wins by default; IF is forced
// through after STARVE_MAX consecutive DM grants while it waits. Reads hold the
// port for RD_LATENCY cycles in WAIT; stores complete in the grant cycle.
// RAM words are stored byte-swapped, and byte addresses are converted to word
// addresses by dropping bit 0. A branch flush squashes the in-flight fetch.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   i_1_if_req/i_A_if_addr   fetch request and byte address
//   o_1_if_gnt/o_1_if_valid  fetch accepted / fetched word is new
//   o_16_if_data             fetched word, held until the next fetch valid
//   i_1_dm_req/i_1_dm_we     data request, 1 = store
//   i_A_dm_addr/i_16_dm_wdata data byte address and store data
//   o_1_dm_gnt/o_1_dm_valid  data accepted / load data is new
//   o_16_dm_rdata            load data, held until the next load valid
//   i_1_flush                squash the granting or outstanding fetch
//   o_1_stall                some requester is waiting
//   i_16_data_mem2cpu        RAM read data
//   o_1_mem_en/rd_en/wr_en   RAM controls
//   o_A_addr_cpu2mem         RAM word address
//   o_16_data_cpu2mem        RAM write data (byte-swapped)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int REG_WIDTH  = 16,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_1_if_req,
    input  logic [ADDR_WIDTH-1:0] i_A_if_addr,
    output logic                  o_1_if_gnt,
    output logic                  o_1_if_valid,
    output logic [REG_WIDTH-1:0]  o_16_if_data,
    input  logic                  i_1_dm_req,
    input  logic                  i_1_dm_we,
    input  logic [ADDR_WIDTH-1:0] i_A_dm_addr,
    input  logic [REG_WIDTH-1:0]  i_16_dm_wdata,
    output logic                  o_1_dm_gnt,
    output logic                  o_1_dm_valid,
    output logic [REG_WIDTH-1:0]  o_16_dm_rdata,
    input  logic                  i_1_flush,
    output logic                  o_1_stall,
    input  logic [REG_WIDTH-1:0]  i_16_data_mem2cpu,
    output logic                  o_1_mem_en,
    output logic                  o_1_mem_rd_en,
    output logic                  o_1_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_A_addr_cpu2mem,
    output logic [REG_WIDTH-1:0]  o_16_data_cpu2mem
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // RD_LATENCY is at most 4, so the countdown fits in 2 bits.
    localparam int CNT_W = 2;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

    function automatic logic [REG_WIDTH-1:0] byte_swap(input logic [REG_WIDTH-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    logic [0:0]            state;
    logic                  owner;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  squash;
    logic [STV_W-1:0]      starve;
    logic                  if_valid_q;
    logic                  dm_valid_q;
    logic [REG_WIDTH-1:0]  if_data_q;
    logic [REG_WIDTH-1:0]  dm_data_q;

    logic                  idle;
    logic                  starved;
    logic                  if_gnt;
    logic                  dm_gnt;
    logic                  rd_gnt;
    logic                  wr_gnt;
    logic                  waiting;
    logic                  squash_now;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign idle    = (state == S_IDLE);
    assign starved = (starve == STV_TOP) && i_1_if_req;

    // Grants only exist in IDLE and never while reset is asserted.
    assign dm_gnt = rst && idle && i_1_dm_req && !starved;
    assign if_gnt = rst && idle && i_1_if_req && (!i_1_dm_req || starved);

    assign rd_gnt  = if_gnt || (dm_gnt && !i_1_dm_we);
    assign wr_gnt  = dm_gnt && i_1_dm_we;
    assign waiting = rst && !idle;

    // A flush arriving in the final WAIT cycle must still suppress the capture.
    assign squash_now = squash || ((owner == OWN_IF) && i_1_flush);

    // With no grant the fetch address is presented, matching the idle behaviour.
    assign sel_addr  = dm_gnt ? i_A_dm_addr : i_A_if_addr;
    assign word_addr = sel_addr >> 1;

    assign o_1_if_gnt        = if_gnt;
    assign o_1_dm_gnt        = dm_gnt;
    assign o_1_mem_en        = rd_gnt || wr_gnt || waiting;
    assign o_1_mem_rd_en     = rd_gnt || waiting;
    assign o_1_mem_wr_en     = wr_gnt;
    assign o_A_addr_cpu2mem  = idle ? word_addr : addr_q;
    assign o_16_data_cpu2mem = byte_swap(i_16_dm_wdata);
    assign o_1_stall         = (i_1_if_req && !if_gnt) || (i_1_dm_req && !dm_gnt);

    assign o_1_if_valid  = if_valid_q;
    assign o_1_dm_valid  = dm_valid_q;
    assign o_16_if_data  = if_data_q;
    assign o_16_dm_rdata = dm_data_q;

    // Grant / WAIT sequencing, capture and registered valid pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IF;
            cnt        <= '0;
            addr_q     <= '0;
            squash     <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_data_q  <= '0;
            dm_data_q  <= '0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_gnt) begin
                        state  <= S_WAIT;
                        owner  <= dm_gnt ? OWN_DM : OWN_IF;
                        cnt    <= CNT_LOAD;
                        addr_q <= word_addr;
                        squash <= if_gnt && i_1_flush;
                    end else begin
                        squash <= 1'b0;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state  <= S_IDLE;
                        squash <= 1'b0;
                        if (owner == OWN_DM) begin
                            dm_data_q  <= byte_swap(i_16_data_mem2cpu);
                            dm_valid_q <= 1'b1;
                        end else if (!squash_now) begin
                            if_data_q  <= byte_swap(i_16_data_mem2cpu);
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt    <= cnt - 1'b1;
                        squash <= squash_now;
                    end
                end
            endcase
        end
    end

    // Consecutive DM grants seen while IF is waiting
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve <= '0;
        end else if (!i_1_if_req || if_gnt) begin
            starve <= '0;
        end else if (dm_gnt && (starve != STV_TOP)) begin
            starve <= starve + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios (reset, fetch, contention, starvation, flush, reset during
// a read) followed by a randomized run checked against a transaction-level
// reference model. A simple word RAM with one cycle of read register sits on
// the memory port. Inputs change 1 ns after the rising edge; outputs are
// checked 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW  = 12;
    localparam int RDL = 2;
    localparam int SMX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_valid;
    logic [15:0]   if_data;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [15:0]   dm_wdata;
    logic          dm_gnt, dm_valid;
    logic [15:0]   dm_rdata;
    logic          flush, stall;
    logic [15:0]   mem_rdata;
    logic          mem_en, mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:4095];

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .REG_WIDTH(16), .RD_LATENCY(RDL), .STARVE_MAX(SMX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_1_if_req(if_req), .i_A_if_addr(if_addr),
        .o_1_if_gnt(if_gnt), .o_1_if_valid(if_valid), .o_16_if_data(if_data),
        .i_1_dm_req(dm_req), .i_1_dm_we(dm_we), .i_A_dm_addr(dm_addr),
        .i_16_dm_wdata(dm_wdata),
        .o_1_dm_gnt(dm_gnt), .o_1_dm_valid(dm_valid), .o_16_dm_rdata(dm_rdata),
        .i_1_flush(flush), .o_1_stall(stall),
        .i_16_data_mem2cpu(mem_rdata),
        .o_1_mem_en(mem_en), .o_1_mem_rd_en(mem_rd), .o_1_mem_wr_en(mem_wr),
        .o_A_addr_cpu2mem(mem_addr), .o_16_data_cpu2mem(mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_en && mem_rd) mem_rdata <= ram[mem_addr];
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_req = 0; dm_req = 0; dm_we = 0; flush = 0;
    endtask

    task automatic test_reset;
        rst = 0; if_req = 1; dm_req = 1; dm_we = 0; if_addr = 12'h010; dm_addr = 12'h020;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt cyc%0d got if=%b dm=%b want 0", i, if_gnt, dm_gnt); end
            checks++; if ({mem_en, mem_rd, mem_wr} !== 3'b000) begin errors++; $display("FAIL reset_mem_ctl cyc%0d got %b want 000", i, {mem_en, mem_rd, mem_wr}); end
            checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d got if=%b dm=%b want 0", i, if_valid, dm_valid); end
            checks++; if (if_data !== 16'h0000 || dm_rdata !== 16'h0000) begin errors++; $display("FAIL reset_data cyc%0d got if=%h dm=%h want 0000", i, if_data, dm_rdata); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_store_fetch;
        rst = 1; dm_req = 1; dm_we = 1; dm_addr = 12'h010; dm_wdata = 16'h1234;
        #1;
        checks++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL store_gnt got dm=%b if=%b want 1/0", dm_gnt, if_gnt); end
        checks++; if ({mem_en, mem_rd, mem_wr} !== 3'b101) begin errors++; $display("FAIL store_ctl got %b want 101", {mem_en, mem_rd, mem_wr}); end
        checks++; if (mem_addr !== 12'h008 || mem_wdata !== 16'h3412) begin errors++; $display("FAIL store_addr_data got %h/%h want 008/3412", mem_addr, mem_wdata); end
        next_cycle();
        idle_inputs(); if_req = 1; if_addr = 12'h010;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt got %b want 1", if_gnt); end
        for (int t = 0; t < 3; t++) begin
            if (t > 0) begin #1; end
            checks++; if (mem_addr !== 12'h008 || mem_rd !== 1'b1 || mem_en !== 1'b1) begin errors++; $display("FAIL fetch_port T+%0d got addr=%h rd=%b en=%b want 008/1/1", t, mem_addr, mem_rd, mem_en); end
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid T+%0d got %b want 0", t, if_valid); end
            next_cycle();
            if_req = 0;
        end
        #1;
        checks++; if (if_valid !== 1'b1 || if_data !== 16'h1234) begin errors++; $display("FAIL fetch_valid T+3 got v=%b d=%h want 1/1234", if_valid, if_data); end
        next_cycle(); #1;
        checks++; if (if_valid !== 1'b0 || if_data !== 16'h1234) begin errors++; $display("FAIL fetch_hold T+4 got v=%b d=%h want 0/1234", if_valid, if_data); end
        next_cycle();
    endtask

    task automatic test_contention;
        dm_req = 1; dm_we = 1; dm_addr = 12'h020; dm_wdata = 16'hBEEF;
        next_cycle();
        if_req = 1; if_addr = 12'h010; dm_req = 1; dm_we = 0; dm_addr = 12'h020;
        #1;
        checks++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL cont_first got dm=%b if=%b st=%b want 1/0/1", dm_gnt, if_gnt, stall); end
        next_cycle(); dm_req = 0;
        for (int t = 1; t < 3; t++) begin
            #1;
            checks++; if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL cont_wait T+%0d got if=%b dm=%b st=%b want 0/0/1", t, if_gnt, dm_gnt, stall); end
            next_cycle();
        end
        #1;
        checks++; if (if_gnt !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL cont_if_gnt got if=%b st=%b want 1/0", if_gnt, stall); end
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== 16'hBEEF) begin errors++; $display("FAIL cont_load got v=%b d=%h want 1/beef", dm_valid, dm_rdata); end
        next_cycle(); if_req = 0;
        next_cycle(); next_cycle(); #1;
        checks++; if (if_valid !== 1'b1 || if_data !== 16'h1234) begin errors++; $display("FAIL cont_fetch got v=%b d=%h want 1/1234", if_valid, if_data); end
        next_cycle();
    endtask

    task automatic test_starvation;
        if_req = 1; if_addr = 12'h010; dm_req = 1; dm_we = 1; dm_addr = 12'h030; dm_wdata = 16'h5A5A;
        for (int round = 0; round < 2; round++) begin
            for (int c = 1; c <= SMX + 1; c++) begin
                #1;
                if (c <= SMX) begin
                    checks++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL starve_dm r%0d c%0d got dm=%b if=%b st=%b want 1/0/1", round, c, dm_gnt, if_gnt, stall); end
                end else begin
                    checks++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin errors++; $display("FAIL starve_if r%0d got if=%b dm=%b want 1/0", round, if_gnt, dm_gnt); end
                end
                next_cycle();
            end
            next_cycle(); next_cycle();
        end
        idle_inputs();
        next_cycle(); next_cycle();
    endtask

    task automatic test_flush;
        logic [15:0] w;
        w = 16'hC0DE;
        dm_req = 1; dm_we = 1; dm_addr = 12'h040; dm_wdata = w;
        next_cycle(); idle_inputs();
        if_req = 1; if_addr = 12'h040;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_gnt got %b want 1", if_gnt); end
        next_cycle(); flush = 1;
        #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", if_gnt); end
        next_cycle(); flush = 0; #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_T2 got %b want 0", if_valid); end
        next_cycle(); #1;
        checks++; if (if_valid !== 1'b0 || if_data !== 16'h1234) begin errors++; $display("FAIL flush_squash got v=%b d=%h want 0/1234", if_valid, if_data); end
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_next_gnt got %b want 1", if_gnt); end
        next_cycle(); if_req = 0;
        next_cycle(); next_cycle(); #1;
        checks++; if (if_valid !== 1'b1 || if_data !== w) begin errors++; $display("FAIL flush_refetch got v=%b d=%h want 1/%h", if_valid, if_data, w); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read;
        dm_req = 1; dm_we = 0; dm_addr = 12'h020;
        #1;
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b want 1", dm_gnt); end
        next_cycle(); dm_req = 0; rst = 0;
        #1;
        checks++; if ({mem_en, mem_rd, mem_wr} !== 3'b000) begin errors++; $display("FAIL rmid_ctl got %b want 000", {mem_en, mem_rd, mem_wr}); end
        next_cycle(); rst = 1; if_req = 1; if_addr = 12'h010;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_regrant got %b want 1", if_gnt); end
        checks++; if (dm_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid1 got %b want 0", dm_valid); end
        next_cycle(); if_req = 0; #1;
        checks++; if (dm_valid !== 1'b0 || dm_rdata !== 16'h0000) begin errors++; $display("FAIL rmid_valid2 got v=%b d=%h want 0/0000", dm_valid, dm_rdata); end
        next_cycle(); next_cycle(); #1;
        checks++; if (if_valid !== 1'b1 || if_data !== 16'h1234) begin errors++; $display("FAIL rmid_fetch got v=%b d=%h want 1/1234", if_valid, if_data); end
        next_cycle();
    endtask

    // Reference: words at byte addresses 0x040..0x04F held in CPU byte order;
    // a read granted in cycle T delivers its word with valid in T+RDL+1.
    task automatic test_random;
        logic [15:0] mm [0:7];
        int          busy, starve, sq;
        logic        own_dm, eg_if, eg_dm, e_st, e_ifv, e_dmv, n_ifv, n_dmv;
        logic [15:0] rd_word, e_ifd, e_dmd;
        for (int i = 0; i < 8; i++) begin
            dm_req = 1; dm_we = 1; dm_addr = AW'(12'h040 + 2 * i); dm_wdata = 16'($urandom);
            mm[i] = dm_wdata;
            #1;
            checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL rnd_fill%0d got %b want 1", i, dm_gnt); end
            next_cycle();
        end
        idle_inputs(); next_cycle();
        busy = 0; starve = 0; sq = 0; own_dm = 0; rd_word = 0;
        e_ifv = 0; e_dmv = 0; e_ifd = 16'h1234; e_dmd = 16'h0000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if_req   = ($urandom_range(0, 3) != 0);
            dm_req   = $urandom_range(0, 1) == 1;
            dm_we    = $urandom_range(0, 1) == 1;
            if_addr  = AW'(12'h040 + $urandom_range(0, 15));
            dm_addr  = AW'(12'h040 + $urandom_range(0, 15));
            dm_wdata = 16'($urandom);
            flush    = ($urandom_range(0, 5) == 0);
            #1;
            if (busy > 0) begin eg_if = 0; eg_dm = 0; end
            else if (starve == SMX && if_req) begin eg_if = 1; eg_dm = 0; end
            else begin eg_dm = dm_req; eg_if = if_req && !dm_req; end
            e_st = (if_req && !eg_if) || (dm_req && !eg_dm);
            checks++; if (if_gnt !== eg_if || dm_gnt !== eg_dm) begin errors++; $display("FAIL rnd_gnt c%0d got if=%b dm=%b want %b/%b", cyc, if_gnt, dm_gnt, eg_if, eg_dm); end
            checks++; if (stall !== e_st) begin errors++; $display("FAIL rnd_stall c%0d got %b want %b", cyc, stall, e_st); end
            checks++; if (if_valid !== e_ifv || dm_valid !== e_dmv) begin errors++; $display("FAIL rnd_valid c%0d got if=%b dm=%b want %b/%b", cyc, if_valid, dm_valid, e_ifv, e_dmv); end
            checks++; if (if_data !== e_ifd || dm_rdata !== e_dmd) begin errors++; $display("FAIL rnd_data c%0d got if=%h dm=%h want %h/%h", cyc, if_data, dm_rdata, e_ifd, e_dmd); end
            n_ifv = 0; n_dmv = 0;
            if (busy > 0) begin
                if (!own_dm && flush) sq = 1;
                busy--;
                if (busy == 0) begin
                    if (own_dm) begin n_dmv = 1; e_dmd = rd_word; end
                    else if (sq == 0) begin n_ifv = 1; e_ifd = rd_word; end
                end
            end else if (eg_dm && dm_we) begin
                mm[(dm_addr - 12'h040) >> 1] = dm_wdata;
            end else if (eg_dm || eg_if) begin
                busy = RDL; own_dm = eg_dm; sq = (eg_if && flush) ? 1 : 0;
                rd_word = eg_dm ? mm[(dm_addr - 12'h040) >> 1] : mm[(if_addr - 12'h040) >> 1];
            end
            if (!if_req || eg_if) starve = 0;
            else if (eg_dm && starve < SMX) starve++;
            e_ifv = n_ifv; e_dmv = n_dmv;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 0; if_req = 0; dm_req = 0; dm_we = 0; flush = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        next_cycle();
        test_reset();
        test_store_fetch();
        test_contention();
        test_starvation();
        test_flush();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port RAM arbiter and access sequencer for the 16-bit CPU. It shares one RAM port between instruction fetch (IF) and data load/store (DM), replacing fixed-delay hazard counting with explicit request/grant/valid handshakes. It generates the pipeline stall signal, handles RAM byte-lane swapping and byte-to-word address conversion, and squashes fetches on branch flush.

## Interface
- ADDR_WIDTH, 12, byte-address width.
- REG_WIDTH, 16, data width; must be 16.
- RD_LATENCY, 1, RAM read latency in cycles; legal range 1..4.
- STARVE_MAX, 4, maximum consecutive DM grants while IF is waiting.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- i_1_if_req  in  1  fetch read request.
- i_A_if_addr  in  ADDR_WIDTH  fetch byte address.
- o_1_if_gnt  out  1  fetch request accepted this cycle.
- o_1_if_valid  out  1  one-cycle pulse when o_16_if_data is new.
- o_16_if_data  out  16  fetched word; holds until the next IF valid.
- i_1_dm_req  in  1  data access request.
- i_1_dm_we  in  1  1 = store, 0 = load.
- i_A_dm_addr  in  ADDR_WIDTH  data byte address.
- i_16_dm_wdata  in  16  store data.
- o_1_dm_gnt  out  1  data request accepted this cycle.
- o_1_dm_valid  out  1  one-cycle pulse when o_16_dm_rdata is new (loads only).
- o_16_dm_rdata  out  16  load data; holds until the next DM valid.
- i_1_flush  in  1  branch taken; squash the outstanding or granting fetch.
- o_1_stall  out  1  a requester is waiting.
- i_16_data_mem2cpu  in  16  RAM read data.
- o_1_mem_en, o_1_mem_rd_en, o_1_mem_wr_en  out  1 each  RAM controls.
- o_A_addr_cpu2mem  out  ADDR_WIDTH  RAM word address.
- o_16_data_cpu2mem  out  16  RAM write data.

## Operation
**FSM states:** IDLE, WAIT. Registers: `owner` (IF or DM), `cnt` (RD_LATENCY-1 down to 0), `addr_q`, `squash`, `starve`.

**IDLE: grants (combinational)**
- Default priority is DM: dm_gnt = dm_req; if_gnt = if_req & ~dm_req.
- Anti-starvation: when starve == STARVE_MAX and if_req = 1, if_gnt = 1 and dm_gnt = 0.

**IDLE: granted store**
- Asserts mem_en = 1 and wr_en = 1 in the grant cycle.
- Write data is byte-swapped: {wdata[7:0], wdata[15:8]}.
- FSM stays in IDLE. No valid pulse is generated.

**IDLE: granted read**
- Asserts mem_en = 1 and rd_en = 1 in the grant cycle.
- Latches addr_q and owner, loads cnt = RD_LATENCY-1, moves to WAIT.

**WAIT**
- Both grants are 0.
- mem_en = 1, rd_en = 1, address = addr_q.
- cnt decrements each cycle.
- When cnt == 0: capture the byte-swapped i_16_data_mem2cpu into the owner's data register, unless owner = IF and squash = 1. Then return to IDLE.

**Valid pulse**
- Registered; asserted in the cycle after capture.
- Suppressed if the capture was squashed.

**Address**
- RAM address = selected byte address >> 1.
- Bit 0 is ignored; misaligned addresses are not flagged.

**Idle RAM outputs**
- With no grant: mem_en, rd_en and wr_en are 0.
- Address = if_addr >> 1.

**Flush**
- squash is set when i_1_flush = 1 during an IF grant cycle or while owner = IF in WAIT. It clears on return to IDLE.
- Flush does not alter the FSM timing, DM transactions, or the RAM controls.

**Starvation counter**
- starve increments on each DM grant while if_req = 1, saturating at STARVE_MAX.
- Cleared on an IF grant, or whenever if_req = 0.

**Stall**
- o_1_stall = (if_req & ~if_gnt) | (dm_req & ~dm_gnt).

**Reset (rst = 0)**
- State goes to IDLE.
- cnt, starve, squash and owner clear to 0.
- Valids and data registers clear to 0.
- All grants and RAM enables are forced to 0.
- Reset during WAIT abandons the read; no valid pulse follows.

## Timing
- Read granted in cycle T: RAM data is sampled at the end of cycle T+RD_LATENCY, and valid is high in T+RD_LATENCY+1.
- The next grant is possible in T+RD_LATENCY+1, giving a throughput of one read per RD_LATENCY+1 cycles.
- Stores take one cycle each, so back-to-back stores are granted every cycle.
- Simultaneous requests in IDLE: exactly one grant. Flush in the same cycle as an IF grant squashes that fetch.
- The first grant is possible in the first cycle after rst returns to 1.

## Test plan
- **Reset:** hold rst = 0 for 3 cycles with both requests high. Required: all grants, valids and RAM enables = 0, and data outputs = 0x0000.
- **Fetch read, RD_LATENCY = 2:** if_addr = 0x010 granted at T. Required: RAM address 0x008 with rd_en = 1 during T..T+2; RAM returns 0x3412; if_valid at T+3 with if_data = 0x1234.
- **Contention:** if_req and dm_req (load, addr 0x020) both high. Required: DM granted first; IF granted the first cycle back in IDLE; stall = 1 until the IF grant.
- **Starvation, STARVE_MAX = 4:** a continuous DM store stream with if_req held high. Required: IF granted on the 5th arbitration cycle; starve returns to 0.
- **Flush:** assert i_1_flush in the cycle after an IF grant. Required: no if_valid pulse, if_data unchanged, and the next grant at the normal T+RD_LATENCY+1.
- **Reset mid-read:** rst = 0 in the WAIT cycle. Required: no valid pulse, FSM in IDLE, and a new request granted the first cycle after reset.
